// File: rtl/hover_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hover_pkg : shared FSM state type, owner encodings and product count |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package hover_pkg;

  localparam int PRODUCT_COUNT = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BAR_HOLD = 2'd1,
    ST_SEL      = 2'd2
  } hover_state_e;

  localparam logic [1:0] OWNER_NONE    = 2'b00;
  localparam logic [1:0] OWNER_BARCODE = 2'b01;
  localparam logic [1:0] OWNER_SELECT  = 2'b10;

  function automatic logic id_valid(input logic [3:0] id);
    return id < 4'(PRODUCT_COUNT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hover_arbiter_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | product_onehot : 4-bit product ID to one-hot vector, zero if ID >= 12 |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module product_onehot
  import hover_pkg::*;
(
  input  logic [3:0]               id_i,
  output logic [PRODUCT_COUNT-1:0] onehot_o,
  output logic                     valid_o
);

  for (genvar i = 0; i < PRODUCT_COUNT; i++) begin : g_bit
    assign onehot_o[i] = (id_i == 4'(i));
  end

  assign valid_o = id_valid(id_i);

endmodule
`default_nettype wire

// File: rtl/hover_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hover_arbiter : arbitrates VGA product highlight between a timed      |
// |                 barcode hover and the interactive cursor selection.   |
// |                 Optional macro HOVER_BLINK_EN blinks the barcode hold.|
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module hover_arbiter
  import hover_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [1:0]               Mode,
  input  logic                     BarcodeDone,
  input  logic [PRODUCT_COUNT-1:0] BarcodeList,
  input  logic [3:0]               SelectedProductID,
  output logic [PRODUCT_COUNT-1:0] HighlightedProductList,
  output logic [1:0]               HoverOwner,
  output logic                     HoldBusy
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be at least 1");
  end

  hover_state_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PRODUCT_COUNT-1:0] list_q, list_d;
  logic                     pend_q, pend_d;
  logic [PRODUCT_COUNT-1:0] sel_q;
  logic                     selv_q;
  logic [PRODUCT_COUNT-1:0] out_q, out_d;
  logic [1:0]               owner_q, owner_d;
  logic                     busy_q, busy_d;

  logic [PRODUCT_COUNT-1:0] sel_oh;
  logic                     sel_valid;
  logic                     mode_on;
  logic                     hold_left;
  logic                     hold_vis;

  product_onehot u_onehot (
    .id_i     (SelectedProductID),
    .onehot_o (sel_oh),
    .valid_o  (sel_valid)
  );

  assign mode_on = |Mode;

  // pend_q marks a hold that is suspended or queued while SEL owns the output
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    list_d    = list_q;
    pend_d    = pend_q;
    hold_left = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (BarcodeDone) begin
          list_d = BarcodeList;
          cnt_d  = HOLD_LOAD;
        end
        if (mode_on) begin
          state_d = ST_SEL;
          pend_d  = BarcodeDone;
        end else if (BarcodeDone) begin
          state_d = ST_BAR_HOLD;
        end
      end
      ST_BAR_HOLD: begin
        hold_left = BarcodeDone || (cnt_q != '0);
        if (BarcodeDone) begin
          list_d = BarcodeList;
          cnt_d  = HOLD_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (mode_on) begin
          state_d = ST_SEL;
          pend_d  = hold_left;
          if (!hold_left) list_d = '0;
        end else if (!hold_left) begin
          state_d = ST_IDLE;
          list_d  = '0;
        end
      end
      ST_SEL: begin
        if (BarcodeDone) begin
          list_d = BarcodeList;
          cnt_d  = HOLD_LOAD;
          pend_d = 1'b1;
        end
        if (!mode_on) begin
          state_d = (pend_q || BarcodeDone) ? ST_BAR_HOLD : ST_IDLE;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        list_d  = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

`ifdef HOVER_BLINK_EN
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               vis_q, vis_d;

  // Every entry or retrigger restarts the blink in its visible half
  always_comb begin
    blink_d = blink_q;
    vis_d   = vis_q;
    if (state_d == ST_BAR_HOLD && (state_q != ST_BAR_HOLD || BarcodeDone)) begin
      blink_d = '0;
      vis_d   = 1'b1;
    end else if (state_q == ST_BAR_HOLD) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        vis_d   = ~vis_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      blink_q <= blink_d;
      vis_q   <= vis_d;
    end
  end

  assign hold_vis = vis_q;
`else
  assign hold_vis = 1'b1;
`endif

  always_comb begin
    out_d   = '0;
    owner_d = OWNER_NONE;
    busy_d  = 1'b0;
    case (state_q)
      ST_BAR_HOLD: begin
        out_d   = hold_vis ? list_q : '0;
        owner_d = OWNER_BARCODE;
        busy_d  = 1'b1;
      end
      ST_SEL: begin
        out_d   = sel_q;
        owner_d = selv_q ? OWNER_SELECT : OWNER_NONE;
        busy_d  = pend_q;
      end
      default: begin
        out_d   = '0;
        owner_d = OWNER_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      list_q  <= '0;
      pend_q  <= 1'b0;
      sel_q   <= '0;
      selv_q  <= 1'b0;
      out_q   <= '0;
      owner_q <= OWNER_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      list_q  <= list_d;
      pend_q  <= pend_d;
      sel_q   <= sel_oh;
      selv_q  <= sel_valid;
      out_q   <= out_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign HighlightedProductList = out_q;
  assign HoverOwner             = owner_q;
  assign HoldBusy               = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hover_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hover_arbiter : vector table, corner sequences and random stimulus |
// |                    against a remaining-cycles reference model.        |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_hover_arbiter;

  localparam int HOLD = 8;
  localparam int BH   = 2;

  logic        CLK;
  logic        RST;
  logic [1:0]  Mode;
  logic        BarcodeDone;
  logic [11:0] BarcodeList;
  logic [3:0]  SelectedProductID;
  logic [11:0] HighlightedProductList;
  logic [1:0]  HoverOwner;
  logic        HoldBusy;

  hover_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .Mode                   (Mode),
    .BarcodeDone            (BarcodeDone),
    .BarcodeList            (BarcodeList),
    .SelectedProductID      (SelectedProductID),
    .HighlightedProductList (HighlightedProductList),
    .HoverOwner             (HoverOwner),
    .HoldBusy               (HoldBusy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: owner kind (0 none, 1 barcode, 2 select) and hold cycles left
  int          m_kind;
  int          m_rem;
  int          m_age;
  int          m_prev_id;
  logic [11:0] m_list;

  typedef struct {
    bit        rst;
    bit [1:0]  mode;
    bit        bd;
    bit [11:0] bl;
    bit [3:0]  id;
    bit [11:0] e_out;
    bit [1:0]  e_own;
    bit        e_busy;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit r, bit [1:0] m, bit b, bit [11:0] l, bit [3:0] i,
                              bit [11:0] eo, bit [1:0] ew, bit eb);
    vec_t v;
    v.rst = r; v.mode = m; v.bd = b; v.bl = l; v.id = i;
    v.e_out = eo; v.e_own = ew; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit [1:0] m, input bit b,
                       input bit [11:0] l, input bit [3:0] i);
    RST = r; Mode = m; BarcodeDone = b; BarcodeList = l; SelectedProductID = i;
  endtask

  task automatic tick();
    logic [11:0] e_out;
    logic [1:0]  e_own;
    logic        e_busy;
    int          nk;
    bit          vis;
    e_out = '0; e_own = 2'd0; e_busy = 1'b0;
    if (RST) begin
      m_kind = 0; m_rem = 0; m_age = 0; m_prev_id = 15; m_list = '0;
    end else begin
      vis = 1'b1;
`ifdef HOVER_BLINK_EN
      vis = ((m_age / BH) % 2) == 0;
`endif
      if (m_kind == 1) begin
        e_out = vis ? m_list : 12'h000; e_own = 2'd1; e_busy = 1'b1;
      end else if (m_kind == 2) begin
        e_out  = (m_prev_id < 12) ? 12'(1 << m_prev_id) : 12'h000;
        e_own  = (m_prev_id < 12) ? 2'd2 : 2'd0;
        e_busy = m_rem > 0;
      end
      nk = m_kind;
      if (m_kind == 1) m_rem--;
      if (BarcodeDone) begin
        m_list = BarcodeList;
        m_rem  = HOLD;
      end
      if (m_kind == 0)      nk = (Mode != 0) ? 2 : (BarcodeDone ? 1 : 0);
      else if (m_kind == 1) nk = (Mode != 0) ? 2 : ((m_rem == 0) ? 0 : 1);
      else                  nk = (Mode != 0) ? 2 : ((m_rem > 0) ? 1 : 0);
      if (m_rem == 0) m_list = '0;
      if (nk == 1 && (m_kind != 1 || BarcodeDone)) m_age = 0;
      else if (nk == 1) m_age++;
      m_kind    = nk;
      m_prev_id = int'(SelectedProductID);
    end
    @(posedge CLK);
    #1;
    chk("model_out", int'(HighlightedProductList), int'(e_out));
    chk("model_owner", int'(HoverOwner), int'(e_own));
    chk("model_busy", int'(HoldBusy), int'(e_busy));
  endtask

  // Counts consecutive cycles showing val; output is left at the first other value
  task automatic run_len(input logic [11:0] val, output int n);
    bit go;
    go = 1'b1;
    n  = 0;
    for (int k = 0; k < 40 && go; k++) begin
      tick();
      if (HighlightedProductList == val) n++;
      else go = 1'b0;
    end
  endtask

  task automatic restart();
    drive(1'b1, 2'd0, 1'b0, 12'h000, 4'hF);
    tick();
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
    tick();
  endtask

  int n;

  initial begin
    drive(1'b1, 2'd0, 1'b0, 12'h000, 4'hF);
    m_kind = 0; m_rem = 0; m_age = 0; m_prev_id = 15; m_list = '0;

    tbl[0]  = mk(1'b1, 2'd0, 1'b0, 12'h000, 4'hF, 12'h000, 2'd0, 1'b0);
    tbl[1]  = mk(1'b0, 2'd0, 1'b0, 12'h000, 4'hF, 12'h000, 2'd0, 1'b0);
    tbl[2]  = mk(1'b0, 2'd1, 1'b0, 12'h000, 4'h3, 12'h000, 2'd0, 1'b0);
    tbl[3]  = mk(1'b0, 2'd1, 1'b0, 12'h000, 4'h3, 12'h008, 2'd2, 1'b0);
    tbl[4]  = mk(1'b0, 2'd1, 1'b0, 12'h000, 4'hD, 12'h008, 2'd2, 1'b0);
    tbl[5]  = mk(1'b0, 2'd1, 1'b0, 12'h000, 4'hD, 12'h000, 2'd0, 1'b0);
    tbl[6]  = mk(1'b0, 2'd1, 1'b1, 12'h100, 4'hD, 12'h000, 2'd0, 1'b0);
    tbl[7]  = mk(1'b0, 2'd1, 1'b0, 12'h000, 4'hB, 12'h000, 2'd0, 1'b1);
    tbl[8]  = mk(1'b0, 2'd0, 1'b0, 12'h000, 4'hB, 12'h800, 2'd2, 1'b1);
    tbl[9]  = mk(1'b0, 2'd0, 1'b0, 12'h000, 4'hB, 12'h100, 2'd1, 1'b1);
    tbl[10] = mk(1'b1, 2'd0, 1'b0, 12'h000, 4'hF, 12'h000, 2'd0, 1'b0);
    tbl[11] = mk(1'b0, 2'd0, 1'b0, 12'h000, 4'hF, 12'h000, 2'd0, 1'b0);
    tbl[12] = mk(1'b0, 2'd2, 1'b1, 12'h040, 4'hF, 12'h000, 2'd0, 1'b0);
    tbl[13] = mk(1'b0, 2'd2, 1'b0, 12'h000, 4'hF, 12'h000, 2'd0, 1'b1);
    tbl[14] = mk(1'b0, 2'd0, 1'b0, 12'h000, 4'hF, 12'h000, 2'd0, 1'b1);
    tbl[15] = mk(1'b0, 2'd0, 1'b0, 12'h000, 4'hF, 12'h040, 2'd1, 1'b1);

    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].rst, tbl[r].mode, tbl[r].bd, tbl[r].bl, tbl[r].id);
      tick();
      chk($sformatf("vec%0d_out", r), int'(HighlightedProductList), int'(tbl[r].e_out));
      chk($sformatf("vec%0d_owner", r), int'(HoverOwner), int'(tbl[r].e_own));
      chk($sformatf("vec%0d_busy", r), int'(HoldBusy), int'(tbl[r].e_busy));
    end

`ifndef HOVER_BLINK_EN
    // Plain hold of 0x010 for exactly HOLD cycles
    restart();
    drive(1'b0, 2'd0, 1'b1, 12'h010, 4'hF);
    tick();
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
    run_len(12'h010, n);
    chk("hold_len", n, HOLD);
    chk("hold_end", int'(HighlightedProductList), 0);
    chk("hold_end_busy", int'(HoldBusy), 0);
`else
    restart();
    drive(1'b0, 2'd0, 1'b1, 12'h001, 4'hF);
    tick();
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
    for (int k = 0; k < HOLD; k++) begin
      tick();
      chk($sformatf("blink%0d", k), int'(HighlightedProductList), ((k % 4) < 2) ? 1 : 0);
      chk($sformatf("blink%0d_owner", k), int'(HoverOwner), 1);
    end
    tick();
    chk("blink_end", int'(HighlightedProductList), 0);
`endif

    // Retrigger on the fifth displayed cycle
    restart();
    drive(1'b0, 2'd0, 1'b1, 12'h010, 4'hF);
    tick();
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
    repeat (5) tick();
    drive(1'b0, 2'd0, 1'b1, 12'h002, 4'hF);
    tick();
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
`ifndef HOVER_BLINK_EN
    run_len(12'h002, n);
    chk("retrig_len", n, HOLD);
    chk("retrig_end", int'(HighlightedProductList), 0);
`else
    repeat (HOLD + 1) tick();
`endif

    // Barcode queued during selection, shown after release
    restart();
    drive(1'b0, 2'd1, 1'b0, 12'h000, 4'hF);
    tick();
    drive(1'b0, 2'd1, 1'b1, 12'h100, 4'hF);
    tick();
    drive(1'b0, 2'd1, 1'b0, 12'h000, 4'hF);
    tick();
    chk("pend_busy", int'(HoldBusy), 1);
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
    tick();
`ifndef HOVER_BLINK_EN
    run_len(12'h100, n);
    chk("pend_len", n, HOLD);
`else
    repeat (HOLD + 1) tick();
`endif

    // Suspend with three cycles left, then resume
    restart();
    drive(1'b0, 2'd0, 1'b1, 12'h010, 4'hF);
    tick();
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
    repeat (4) tick();
    drive(1'b0, 2'd2, 1'b0, 12'h000, 4'hF);
    tick();
    chk("susp_last", int'(HighlightedProductList), 12'h010);
    repeat (3) tick();
    chk("susp_out", int'(HighlightedProductList), 0);
    chk("susp_busy", int'(HoldBusy), 1);
    drive(1'b0, 2'd0, 1'b0, 12'h000, 4'hF);
    tick();
`ifndef HOVER_BLINK_EN
    run_len(12'h010, n);
    chk("resume_len", n, 3);
    chk("resume_end", int'(HighlightedProductList), 0);
`else
    repeat (5) tick();
`endif

    // Random traffic against the model
    restart();
    for (int c = 0; c < 800; c++) begin
      RST = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0)
        Mode = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      BarcodeDone = ($urandom_range(0, 5) == 0);
      BarcodeList = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'(1 << $urandom_range(0, 11));
      SelectedProductID = 4'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
